display_scan_controller: RTL and testbench

Sequencer for the 8-digit multiplexed seven-segment display path. It generates the digit refresh tick and scan index, and drives the active-low anodes and the 4-bit digit nibble that feed the existing hex-to-7-segment decoder. It holds a double-buffered 32-bit display value loaded through a valid/ready handshake and committed only at frame boundaries, so the display never tears. It also applies per-digit blanking, leading-zero suppression and whole-display blink.

---
 rtl/disp_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 26 ++
 rtl/display_scan_controller.sv | 106 ++++++++++
 tb/tb_display_scan_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan path.
package disp_pkg;

    localparam int N_DIGITS = 8;
    localparam int IDX_W    = 3;

    typedef logic [3:0] nibble_t;

    typedef enum logic {ST_EMPTY, ST_FULL} buf_state_t;

    // Index of the most significant nonzero nibble; 0 when the value is all zero.
    function automatic logic [IDX_W-1:0] msd_index(input logic [31:0] value);
        msd_index = '0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (value[4*k +: 4] != 4'h0) msd_index = k[IDX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enabled modulo-DIV counter emitting a one-cycle tick on its last count.
module tick_prescaler #(
    parameter int DIV   = 2,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// 8-digit seven-segment scan sequencer with frame-synchronous double buffering,
// per-digit blanking, leading-zero suppression and whole-display blink.
module display_scan_controller
    import disp_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [7:0]  blank_mask,
    input  logic        lz_blank,
    input  logic        blink_en,
    output logic [3:0]  digit_data,
    output logic [7:0]  anodes,
    output logic        frame_done
);

    logic             tick;
    logic             boundary;
    logic             blink_wrap;
    logic             blink_phase;
    logic             blanked;
    logic [IDX_W-1:0] idx;
    logic [31:0]      active;
    logic [31:0]      pending;
    nibble_t          cur_nibble;
    buf_state_t       state;

    tick_prescaler #(
        .DIV   (TICK_DIV),
        .CNT_W ($clog2(TICK_DIV))
    ) u_scan_div (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .tick  (tick)
    );

    assign boundary = tick && (idx == IDX_W'(N_DIGITS - 1));

    // Same counter reused as a frame counter: it only advances on frame boundaries.
    tick_prescaler #(
        .DIV   (BLINK_FRAMES),
        .CNT_W ($clog2(BLINK_FRAMES + 1))
    ) u_blink_div (
        .clock (clock),
        .reset (reset),
        .en    (boundary),
        .tick  (blink_wrap)
    );

    always_comb begin
        cur_nibble = active[{idx, 2'b00} +: 4];
        blanked    = blank_mask[idx]
                  || (lz_blank && (idx > msd_index(active)))
                  || (blink_en && !blink_phase);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            frame_done  <= 1'b0;
            blink_phase <= 1'b1;
            state       <= ST_EMPTY;
            data_ready  <= 1'b1;
            pending     <= '0;
            active      <= '0;
            digit_data  <= '0;
            anodes      <= 8'hFF;
        end else begin
            if (tick) idx <= idx + IDX_W'(1);
            frame_done <= boundary;
            if (blink_wrap) blink_phase <= ~blink_phase;

            digit_data <= cur_nibble;
            anodes     <= blanked ? 8'hFF : ~(8'b1 << idx);

            // active only changes on a frame boundary so a frame never mixes two values
            case (state)
                ST_EMPTY: begin
                    if (data_valid && data_ready) begin
                        pending    <= data_in;
                        state      <= ST_FULL;
                        data_ready <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (boundary) begin
                        active     <= pending;
                        state      <= ST_EMPTY;
                        data_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    data_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised scoreboard bench for display_scan_controller with a cycle-count reference model.
module tb_display_scan_controller;

    localparam int TD = 4;
    localparam int BF = 2;

    logic        clock;
    logic        reset;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  blank_mask;
    logic        lz_blank;
    logic        blink_en;
    logic [3:0]  digit_data;
    logic [7:0]  anodes;
    logic        frame_done;

    display_scan_controller #(
        .TICK_DIV     (TD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .blank_mask (blank_mask),
        .lz_blank   (lz_blank),
        .blink_en   (blink_en),
        .digit_data (digit_data),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    typedef struct {
        logic       ready;
        logic [7:0] an;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: cycles since reset release, buffer contents, boundaries seen
    int          m_n = 0;
    bit          m_full = 0;
    logic [31:0] m_pending = '0;
    logic [31:0] m_active = '0;
    int          m_frames = 0;

    logic [7:0] cur_mask = '0;
    logic       cur_lz = 0;
    logic       cur_blink = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic int ref_msd(input logic [31:0] v);
        int r = 0;
        logic [31:0] t = v;
        while (t >= 32'd16) begin
            t = t / 16;
            r++;
        end
        return r;
    endfunction

    function automatic int m_idx();
        return (m_n / TD) % 8;
    endfunction

    function automatic bit m_boundary();
        return ((m_n % TD) == TD - 1) && (m_idx() == 7);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One clock of stimulus: drive inputs, predict outputs after the next edge, advance the model.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        exp_t e;
        int   idx;
        bit   bnd, on, blk;
        @(negedge clock);
        data_valid = v;
        data_in    = d;
        reset      = r;
        blank_mask = cur_mask;
        lz_blank   = cur_lz;
        blink_en   = cur_blink;
        if (r) begin
            m_n = 0; m_full = 0; m_pending = '0; m_active = '0; m_frames = 0;
            e.ready = 1'b1; e.an = 8'hFF; e.dig = 4'h0; e.fd = 1'b0;
        end else begin
            idx = m_idx();
            bnd = m_boundary();
            on  = ((m_frames / BF) % 2) == 0;
            blk = cur_mask[idx] || (cur_lz && idx > ref_msd(m_active)) || (cur_blink && !on);
            e.dig = 4'((m_active >> (4 * idx)) & 32'hF);
            e.an  = blk ? 8'hFF : (8'hFF ^ 8'(1 << idx));
            e.fd  = bnd;
            if (!m_full && v) begin
                m_pending = d;
                m_full    = 1;
            end else if (m_full && bnd) begin
                m_active = m_pending;
                m_full   = 0;
            end
            e.ready = !m_full;
            if (bnd) m_frames++;
            m_n++;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_model(input int mode, input int limit);
        int  i = 0;
        bit  ok = 0;
        while (i < limit && !ok) begin
            case (mode)
                0: ok = !m_full;
                1: ok = m_boundary() && !m_full;
                2: ok = m_full && (m_idx() == 5);
                default: ok = !m_full && (m_idx() == 0) && ((m_n % TD) == 0);
            endcase
            if (!ok) begin
                cyc(1'b0, 32'h0, 1'b0);
                i++;
            end
        end
        if (!ok) check($sformatf("wait_mode%0d_timeout", mode), 32'd0, 32'd1);
    endtask

    // Monitor: DUT presents outputs every cycle; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (data_ready !== e.ready || anodes !== e.an || digit_data !== e.dig || frame_done !== e.fd) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t got rdy=%b an=%h dig=%h fd=%b, expected rdy=%b an=%h dig=%h fd=%b",
                             $time, data_ready, anodes, digit_data, frame_done, e.ready, e.an, e.dig, e.fd);
                end
            end
        end
    end

    initial begin
        reset = 1; data_valid = 0; data_in = '0; blank_mask = '0; lz_blank = 0; blink_en = 0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
        check("reset_anodes", {24'h0, anodes}, 32'hFF);
        check("reset_ready", {31'h0, data_ready}, 32'h1);
        check("reset_digit", {28'h0, digit_data}, 32'h0);
        check("reset_frame_done", {31'h0, frame_done}, 32'h0);

        // plain scan, then a mid-frame load with a second offer while full
        idle(70);
        wait_model(3, 100);
        idle(9);
        cyc(1'b1, 32'h1234ABCD, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hDEADBEEF, 1'b0);
        idle(80);

        // leading-zero suppression and digit masking
        cur_lz = 1;
        wait_model(0, 100);
        cyc(1'b1, 32'h00000A05, 1'b0);
        idle(80);
        cyc(1'b1, 32'h00000000, 1'b0);
        idle(80);
        cur_mask = 8'h01;
        idle(40);
        cur_mask = 8'h00;
        cur_lz = 0;

        // blink over several frames
        cur_blink = 1;
        idle(170);
        cur_blink = 0;
        idle(20);

        // offer exactly on the boundary cycle: must commit one frame later
        wait_model(1, 100);
        cyc(1'b1, 32'h0F0F5A5A, 1'b0);
        idle(70);

        // reset while the scan is at digit 5 with data pending
        wait_model(3, 100);
        cyc(1'b1, 32'h87654321, 1'b0);
        wait_model(2, 100);
        cyc(1'b0, 32'h0, 1'b1);
        #1;
        check("midreset_anodes", {24'h0, anodes}, 32'hFF);
        check("midreset_ready", {31'h0, data_ready}, 32'h1);
        check("midreset_digit", {28'h0, digit_data}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        idle(70);

        // randomised traffic and control segments
        for (int s = 0; s < 40; s++) begin
            cur_lz    = ($urandom_range(0, 1) == 1);
            cur_blink = ($urandom_range(0, 2) == 0);
            cur_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            for (int i = 0; i < 64; i++) begin
                logic [31:0] d;
                case ($urandom_range(0, 4))
                    0: d = 32'h1234ABCD;
                    1: d = 32'h00000A05;
                    2: d = 32'h00000000;
                    3: d = $urandom;
                    default: d = $urandom & 32'h00000FFF;
                endcase
                cyc(($urandom_range(0, 7) == 0), d, 1'b0);
            end
        end

        begin
            int t = 0;
            while (sb_q.size() > 0 && t < 10) begin
                @(posedge clock);
                t++;
            end
            #2;
            if (sb_q.size() > 0) check("drain_timeout", sb_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
